// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states; the encoding is exported on state_o for debug.
    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_state_e;

    // Width of the saturating relock event counter.
    localparam int RELOCK_W = 8;

    // Largest of four values, used to size the shared timer.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into the local clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; both clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises the system PLL: pulses its reset, waits for a stable lock,
// then releases the downstream domain resets one at a time. Lock loss or a
// software request re-arms the PLL from the beginning.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int N_DOMAINS     = 5,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 64,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                 refclk,
    input  logic                 rst,
    output logic                 pll_rst,
    input  logic                 pll_locked,
    input  logic                 sw_relock,
    output logic [N_DOMAINS-1:0] dom_rst,
    output logic                 all_ready,
    output logic                 lock_fail,
    output logic [RELOCK_W-1:0]  relock_count,
    output logic [2:0]           state_o
);

    localparam int TW = $clog2(max_of4(LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP, RST_CYCLES)) + 1;
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(RELEASE_GAP - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    pll_state_e            state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [RW-1:0]         retry, retry_n;
    logic                  pll_rst_n, all_ready_n, lock_fail_n;
    logic [N_DOMAINS-1:0]  dom_rst_n;
    logic [RELOCK_W-1:0]   relock_n;
    logic                  locked_s;
    logic                  restart, count_loss;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n     = state;
        timer_n     = timer + 1'b1;
        retry_n     = retry;
        pll_rst_n   = pll_rst;
        dom_rst_n   = dom_rst;
        all_ready_n = all_ready;
        lock_fail_n = lock_fail;
        relock_n    = relock_count;
        restart     = 1'b0;
        count_loss  = 1'b0;

        case (state)
            PLL_RESET: begin
                // sw_relock is deliberately ignored: the PLL is already in reset.
                if (timer == RST_LAST) begin
                    state_n   = WAIT_LOCK;
                    timer_n   = '0;
                    pll_rst_n = 1'b0;
                end
            end
            WAIT_LOCK: begin
                if (sw_relock) begin
                    restart = 1'b1;
                end else if (locked_s) begin
                    state_n = STABLE;
                    timer_n = '0;
                    retry_n = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    state_n   = PLL_RESET;
                    timer_n   = '0;
                    pll_rst_n = 1'b1;
                    if (retry != RETRY_MAX) retry_n = retry + 1'b1;
                    if (retry_n == RETRY_MAX) lock_fail_n = 1'b1;
                end
            end
            STABLE: begin
                if (sw_relock) begin
                    restart = 1'b1;
                end else if (!locked_s) begin
                    // A glitch before release is not a relock event.
                    state_n = WAIT_LOCK;
                    timer_n = '0;
                end else if (timer == STABLE_LAST) begin
                    state_n      = RELEASE;
                    timer_n      = '0;
                    dom_rst_n[0] = 1'b0;
                end
            end
            RELEASE: begin
                if (!locked_s || sw_relock) begin
                    restart    = 1'b1;
                    count_loss = !locked_s;
                end else if (!dom_rst[N_DOMAINS-1]) begin
                    state_n     = RUN;
                    timer_n     = '0;
                    all_ready_n = 1'b1;
                end else if (timer == GAP_LAST) begin
                    // dom_rst is a thermometer code: clear its lowest set bit.
                    timer_n   = '0;
                    dom_rst_n = dom_rst & ~(dom_rst & (~dom_rst + 1'b1));
                end
            end
            RUN: begin
                timer_n = '0;
                if (!locked_s || sw_relock) begin
                    restart    = 1'b1;
                    count_loss = !locked_s;
                end
            end
            default: begin
                restart = 1'b1;
            end
        endcase

        // Common re-arm path; a lock loss wins over a coincident sw_relock.
        if (restart) begin
            state_n     = PLL_RESET;
            timer_n     = '0;
            pll_rst_n   = 1'b1;
            dom_rst_n   = '1;
            all_ready_n = 1'b0;
            if (count_loss && (relock_count != '1)) relock_n = relock_count + 1'b1;
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= PLL_RESET;
            timer        <= '0;
            retry        <= '0;
            pll_rst      <= 1'b1;
            dom_rst      <= '1;
            all_ready    <= 1'b0;
            lock_fail    <= 1'b0;
            relock_count <= '0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            retry        <= retry_n;
            pll_rst      <= pll_rst_n;
            dom_rst      <= dom_rst_n;
            all_ready    <= all_ready_n;
            lock_fail    <= lock_fail_n;
            relock_count <= relock_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with reduced timing parameters.
module tb_pll_reset_sequencer;

    localparam int N_DOM = 5;

    logic             refclk;
    logic             rst;
    logic             pll_rst;
    logic             pll_locked;
    logic             sw_relock;
    logic [N_DOM-1:0] dom_rst;
    logic             all_ready;
    logic             lock_fail;
    logic [7:0]       relock_count;
    logic [2:0]       state_o;

    int tests = 0;
    int fails = 0;

    pll_reset_sequencer #(
        .N_DOMAINS     (N_DOM),
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .RELEASE_GAP   (3),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_rst      (pll_rst),
        .pll_locked   (pll_locked),
        .sw_relock    (sw_relock),
        .dom_rst      (dom_rst),
        .all_ready    (all_ready),
        .lock_fail    (lock_fail),
        .relock_count (relock_count),
        .state_o      (state_o)
    );

    // Clock: 10 ns period, inputs driven and outputs sampled on the falling edge.
    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Safety net in case a bounded wait is ever bypassed.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       locked;
        logic       relock;
        int         n;
        logic [2:0] st;
        logic       pr;
        logic [4:0] dom;
        logic       rdy;
        logic       lf;
        logic [7:0] rc;
    } vec_t;

    vec_t vecs[16];
    int   n_vecs = 0;

    task automatic add_vec(input logic r, input logic lk, input logic rl, input int n,
                           input logic [2:0] st, input logic pr, input logic [4:0] dom,
                           input logic rdy, input logic lf, input logic [7:0] rc);
        vecs[n_vecs] = '{r, lk, rl, n, st, pr, dom, rdy, lf, rc};
        n_vecs++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks, sampling on each falling edge; all_ready must imply released resets.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            @(negedge refclk);
            if (all_ready === 1'b1) begin
                tests++;
                if (dom_rst !== '0 || pll_rst !== 1'b0) begin
                    fails++;
                    $display("FAIL ready_invariant: got dom_rst=%0h pll_rst=%0b expected 0 0", dom_rst, pll_rst);
                end
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k;
        k = 0;
        while (state_o !== s && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(state_o), 32'(s));
    endtask

    task automatic wait_dom(input logic [4:0] d, input int budget, input string name);
        int k;
        k = 0;
        while (dom_rst !== d && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(dom_rst), 32'(d));
    endtask

    task automatic pulse_relock;
        sw_relock = 1'b1;
        step(1);
        sw_relock = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic pr,
                             input logic [4:0] dom, input logic rdy, input logic lf,
                             input logic [7:0] rc);
        check({tag, " state"},     32'(state_o),      32'(st));
        check({tag, " pll_rst"},   32'(pll_rst),      32'(pr));
        check({tag, " dom_rst"},   32'(dom_rst),      32'(dom));
        check({tag, " all_ready"}, 32'(all_ready),    32'(rdy));
        check({tag, " lock_fail"}, 32'(lock_fail),    32'(lf));
        check({tag, " relock"},    32'(relock_count), 32'(rc));
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        sw_relock  = 1'b0;

        // Nominal bring-up, then lock loss in RUN.
        //       rst lk rl  n   st    pr  dom    rdy lf rc
        add_vec(1, 0, 0, 2, 3'd0, 1, 5'h1F, 0, 0, 0);
        add_vec(0, 0, 0, 3, 3'd0, 1, 5'h1F, 0, 0, 0);
        add_vec(0, 0, 0, 1, 3'd1, 0, 5'h1F, 0, 0, 0);
        add_vec(0, 0, 0, 9, 3'd1, 0, 5'h1F, 0, 0, 0);
        add_vec(0, 1, 0, 2, 3'd1, 0, 5'h1F, 0, 0, 0);
        add_vec(0, 1, 0, 1, 3'd2, 0, 5'h1F, 0, 0, 0);
        add_vec(0, 1, 0, 7, 3'd2, 0, 5'h1F, 0, 0, 0);
        add_vec(0, 1, 0, 1, 3'd3, 0, 5'h1E, 0, 0, 0);
        add_vec(0, 1, 0, 2, 3'd3, 0, 5'h1E, 0, 0, 0);
        add_vec(0, 1, 0, 1, 3'd3, 0, 5'h1C, 0, 0, 0);
        add_vec(0, 1, 0, 3, 3'd3, 0, 5'h18, 0, 0, 0);
        add_vec(0, 1, 0, 3, 3'd3, 0, 5'h10, 0, 0, 0);
        add_vec(0, 1, 0, 3, 3'd3, 0, 5'h00, 0, 0, 0);
        add_vec(0, 1, 0, 1, 3'd4, 0, 5'h00, 1, 0, 0);
        add_vec(0, 0, 0, 2, 3'd4, 0, 5'h00, 1, 0, 0);
        add_vec(0, 0, 0, 1, 3'd0, 1, 5'h1F, 0, 0, 1);

        for (int i = 0; i < n_vecs; i++) begin
            rst        = vecs[i].rst;
            pll_locked = vecs[i].locked;
            sw_relock  = vecs[i].relock;
            step(vecs[i].n);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pr, vecs[i].dom,
                      vecs[i].rdy, vecs[i].lf, vecs[i].rc);
        end

        // Re-sequence after the lock loss.
        pll_locked = 1'b1;
        wait_state(3'd4, 200, "reseq run");
        check_all("reseq", 3'd4, 0, 5'h00, 1, 0, 1);

        // sw_relock in RUN: re-arm without counting a relock.
        pulse_relock();
        check_all("swrl_run", 3'd0, 1, 5'h1F, 0, 0, 1);

        // sw_relock during PLL_RESET must not stretch the reset pulse.
        pulse_relock();
        check("swrl_prst state1", 32'(state_o), 32'(3'd0));
        step(2);
        check("swrl_prst state3", 32'(state_o), 32'(3'd0));
        check("swrl_prst pll_rst3", 32'(pll_rst), 32'(1'b1));
        step(1);
        check("swrl_prst state4", 32'(state_o), 32'(3'd1));
        check("swrl_prst pll_rst4", 32'(pll_rst), 32'(1'b0));
        wait_state(3'd4, 200, "swrl_prst run");
        check("swrl_prst relock", 32'(relock_count), 32'(8'd1));

        // Lock loss coincident with sw_relock after dom_rst[1] has cleared.
        pulse_relock();
        wait_dom(5'h1C, 200, "mid_rel dom");
        check("mid_rel state", 32'(state_o), 32'(3'd3));
        pll_locked = 1'b0;
        step(2);
        check("mid_rel hold state", 32'(state_o), 32'(3'd3));
        check("mid_rel hold dom", 32'(dom_rst), 32'(5'h1C));
        sw_relock = 1'b1;
        step(1);
        sw_relock = 1'b0;
        check_all("mid_rel loss", 3'd0, 1, 5'h1F, 0, 0, 2);
        pll_locked = 1'b1;
        wait_state(3'd4, 200, "mid_rel run");
        check("mid_rel relock", 32'(relock_count), 32'(8'd2));

        // One-cycle lock glitch after five STABLE cycles.
        pulse_relock();
        wait_state(3'd2, 50, "glitch stable");
        step(4);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        check("glitch h1", 32'(state_o), 32'(3'd2));
        step(1);
        check("glitch h2", 32'(state_o), 32'(3'd2));
        step(1);
        check("glitch wait_lock", 32'(state_o), 32'(3'd1));
        check("glitch dom", 32'(dom_rst), 32'(5'h1F));
        step(1);
        check("glitch restable", 32'(state_o), 32'(3'd2));
        step(7);
        check("glitch stable7", 32'(state_o), 32'(3'd2));
        check("glitch dom7", 32'(dom_rst), 32'(5'h1F));
        step(1);
        check("glitch release", 32'(state_o), 32'(3'd3));
        check("glitch release dom", 32'(dom_rst), 32'(5'h1E));
        check("glitch relock", 32'(relock_count), 32'(8'd2));
        wait_state(3'd4, 200, "glitch run");

        // rst during RELEASE, then lock timeouts with pll_locked held low.
        pulse_relock();
        wait_dom(5'h1C, 200, "rst_rel dom");
        rst        = 1'b1;
        pll_locked = 1'b0;
        step(1);
        check_all("rst_rel", 3'd0, 1, 5'h1F, 0, 0, 0);
        rst = 1'b0;
        step(3);
        check("to t3 state", 32'(state_o), 32'(3'd0));
        step(1);
        check("to t4 state", 32'(state_o), 32'(3'd1));
        step(19);
        check("to t23 state", 32'(state_o), 32'(3'd1));
        check("to t23 lock_fail", 32'(lock_fail), 32'(1'b0));
        step(1);
        check("to t24 state", 32'(state_o), 32'(3'd0));
        check("to t24 pll_rst", 32'(pll_rst), 32'(1'b1));
        check("to t24 lock_fail", 32'(lock_fail), 32'(1'b0));
        step(4);
        check("to t28 state", 32'(state_o), 32'(3'd1));
        step(19);
        check("to t47 state", 32'(state_o), 32'(3'd1));
        check("to t47 lock_fail", 32'(lock_fail), 32'(1'b0));
        step(1);
        check("to t48 state", 32'(state_o), 32'(3'd0));
        check("to t48 lock_fail", 32'(lock_fail), 32'(1'b1));
        pll_locked = 1'b1;
        wait_state(3'd4, 200, "to run");
        check_all("to locked", 3'd4, 0, 5'h00, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Supervises the system PLL that generates the 50/100/100-shifted/12/12 MHz clocks from the 50 MHz reference. Runs on the free-running reference clock and drives the PLL reset. It monitors lock, and releases per-clock-domain resets in a fixed order only after lock has been stable. On lock loss or a software request it re-arms the PLL and reports failures.

Parameters:
N_DOMAINS, 5, number of downstream domain resets; bit i maps to PLL output i.
RST_CYCLES, 16, refclk cycles the PLL reset is held high.
LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before a retry (1 ms).
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release.
RELEASE_GAP, 64, refclk cycles between successive domain reset releases.
MAX_RETRIES, 4, consecutive timeouts before lock_fail is set.

Ports:
refclk  in  1  50 MHz reference clock; sole clock of the block.
rst  in  1  synchronous, active-high reset.
pll_rst  out  1  reset to the PLL, active high.
pll_locked  in  1  PLL locked output; asynchronous to refclk.
sw_relock  in  1  single-cycle pulse requesting a full re-lock.
dom_rst  out  N_DOMAINS  per-domain reset, active high; each consumer synchronizes it locally.
all_ready  out  1  high only in RUN.
lock_fail  out  1  sticky: MAX_RETRIES consecutive timeouts occurred.
relock_count  out  8  count of lock-loss events after RUN/RELEASE was reached; saturates at 255.
state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst=1 at an edge): state=PLL_RESET, pll_rst=1, dom_rst=all 1, all_ready=0, lock_fail=0, relock_count=0, retry count=0, all timers=0.
- All outputs are registered. pll_locked goes through a 2-flop synchronizer (locked_s), so each input change appears 2 cycles later.
- PLL_RESET:
  - pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with timer cleared.
  - sw_relock is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0.
  - locked_s=1 goes to STABLE.
  - The timer reaching LOCK_TIMEOUT-1 without lock goes to PLL_RESET and increments the retry count (saturating).
  - Retry count == MAX_RETRIES sets lock_fail; it stays set until rst, and retries continue.
  - Entry into STABLE clears the retry count.
- STABLE:
  - Counts consecutive cycles with locked_s=1.
  - locked_s=0 returns to WAIT_LOCK with the timeout timer cleared; this is not counted as a relock.
  - STABLE_CYCLES reached goes to RELEASE.
- RELEASE:
  - dom_rst[0] clears in the first RELEASE cycle.
  - dom_rst[i] clears RELEASE_GAP cycles after dom_rst[i-1].
  - The cycle after dom_rst[N_DOMAINS-1] clears, go to RUN; all_ready=1 from that cycle on.
- RUN: hold all outputs.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - Next edge: dom_rst=all 1, all_ready=0, pll_rst=1, state=PLL_RESET, relock_count+1.
- sw_relock in WAIT_LOCK, STABLE, RELEASE or RUN: same as lock loss but relock_count is not incremented.
- Lock loss and sw_relock in the same cycle: handle as a lock loss, incrementing once.
- rst mid-sequence: immediate return to the reset values at the next edge, regardless of state.
- Timer width: clog2 of the max of LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP, RST_CYCLES, plus 1.
- One shared timer is cleared on every state transition.
- Invariant: all_ready=1 implies dom_rst=0 and pll_rst=0.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4;
  - the relock_count width constant (8).
- One sub-module: sync_2ff (parameterized width, reset value 0), used for pll_locked.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, RELEASE_GAP=3, MAX_RETRIES=2, N_DOMAINS=5.
1. Nominal bring-up: rst low; pll_locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; dom_rst bits clear at 3-cycle spacing 0..4; all_ready=1; lock_fail=0; relock_count=0.
2. Lock timeout: pll_locked held 0 -> PLL_RESET re-entered every 24 cycles; lock_fail set on the 2nd timeout and still set after locking on the 3rd attempt.
3. Lock glitch in STABLE: drop pll_locked for 1 cycle after 5 stable cycles -> return to WAIT_LOCK; no release; relock_count=0; release occurs after 8 uninterrupted cycles.
4. Lock loss in RUN: drop pll_locked -> 3 cycles after the drop, dom_rst=5'h1F, all_ready=0, pll_rst=1, relock_count=1; full re-sequence follows.
5. Loss mid-RELEASE with simultaneous sw_relock, after dom_rst[1] has cleared -> all dom_rst re-asserted; relock_count increments by exactly 1.
6. sw_relock in PLL_RESET ignored; in RUN -> re-sequence with relock_count unchanged. rst asserted during RELEASE -> reset values next edge.
